// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared USB line-state constants, TX state enum and
//                bit-stuffing threshold for the PHY encoder/decoder pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    localparam logic [1:0] c_LS_SE0     = 2'b00;
    localparam logic [1:0] c_LS_J       = 2'b01;
    localparam logic [1:0] c_LS_K       = 2'b10;
    localparam logic [1:0] c_LS_ILLEGAL = 2'b11;

    localparam logic [2:0] c_STUFF_THRESH = 3'd6;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SYNC    = 3'd1,
        TX_DATA    = 3'd2,
        TX_EOP_SE0 = 3'd3,
        TX_EOP_J   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_tx_bit_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_bit_stuffer
//  Description : Consecutive-ones counter, stuff request and NRZI level
//                register; advances once per transmitted bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_bit_stuffer
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic step,
    input  logic bit_in,
    output logic stuff_req,
    output logic level
);

    logic [2:0] r_ones;
    logic       r_level;

    // r_level = 1 means the line currently rests at J
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_ones  <= 3'd0;
            r_level <= 1'b1;
        end else if (step) begin
            r_level <= bit_in ? r_level : ~r_level;
            r_ones  <= bit_in ? (r_ones + 3'd1) : 3'd0;
        end
    end

    assign stuff_req = (r_ones == c_STUFF_THRESH);
    assign level     = r_level;

endmodule
`default_nettype wire

// File: rtl/usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_line_encoder
//  Description : Full-speed USB transmit line encoder: SYNC, LSB-first
//                serialisation, bit stuffing, NRZI and EOP on D+/D-.
//                Define USB_TX_LS_EN for low-speed pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_line_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       usb_oe,
    output logic [1:0] tx_line_state
);

    localparam int c_TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(CLKS_PER_BIT - 1);

`ifdef USB_TX_LS_EN
    localparam logic c_LOW_SPEED = 1'b1;
`else
    localparam logic c_LOW_SPEED = 1'b0;
`endif

    function automatic logic f_dp(input logic [1:0] ls);
        return c_LOW_SPEED ? (ls == c_LS_K) : (ls == c_LS_J);
    endfunction

    function automatic logic f_dn(input logic [1:0] ls);
        return c_LOW_SPEED ? (ls == c_LS_J) : (ls == c_LS_K);
    endfunction

    tx_state_t              r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic [1:0]             r_line_state;
    logic                   r_dp;
    logic                   r_dn;
    logic                   r_oe;
    logic                   r_active;
    logic                   r_holdoff;

    tx_state_t              w_state_nxt;
    logic                   w_last;
    logic                   w_empty;
    logic                   w_step;
    logic                   w_bit;
    logic                   w_clear;
    logic [2:0]             w_bit_cnt_nxt;
    logic [6:0]             w_shift_nxt;
    logic [1:0]             w_ls_nxt;
    logic                   w_stuff_req;
    logic                   w_level;

    usb_tx_bit_stuffer u_stuffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .step      (w_step),
        .bit_in    (w_bit),
        .stuff_req (w_stuff_req),
        .level     (w_level)
    );

    assign w_last = (r_timer == c_TIMER_LAST);

    // Shift register empties after the last SYNC bit or the 8th data bit,
    // unless a stuff bit is still owed for that data bit.
    assign w_empty = w_last && (r_bit_cnt == 3'd7) &&
                     ((r_state == TX_SYNC) || ((r_state == TX_DATA) && !w_stuff_req));

    assign tx_ready = w_empty && tx_valid;

    always_comb begin
        w_state_nxt   = r_state;
        w_step        = 1'b0;
        w_bit         = 1'b0;
        w_clear       = 1'b0;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ls_nxt      = r_line_state;

        case (r_state)
            TX_IDLE: begin
                if (tx_valid && !r_holdoff) begin
                    w_state_nxt   = TX_SYNC;
                    w_step        = 1'b1;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            TX_SYNC: begin
                if (w_last && !w_empty) begin
                    w_step        = 1'b1;
                    w_bit         = (r_bit_cnt == 3'd6);
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                end
            end
            TX_DATA: begin
                if (w_last && !w_empty) begin
                    w_step = 1'b1;
                    if (!w_stuff_req) begin
                        w_bit         = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[6:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            TX_EOP_SE0: begin
                if (w_last) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_bit_cnt_nxt = 3'd1;
                    end else begin
                        w_state_nxt = TX_EOP_J;
                        w_ls_nxt    = c_LS_J;
                    end
                end
            end
            TX_EOP_J: begin
                if (w_last) begin
                    w_state_nxt = TX_IDLE;
                    w_ls_nxt    = c_LS_J;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_ls_nxt    = c_LS_J;
            end
        endcase

        if (w_empty) begin
            w_bit_cnt_nxt = 3'd0;
            if (tx_valid) begin
                w_state_nxt = TX_DATA;
                w_step      = 1'b1;
                w_bit       = tx_data[0];
                w_shift_nxt = tx_data[7:1];
            end else begin
                w_state_nxt = TX_EOP_SE0;
                w_clear     = 1'b1;
                w_ls_nxt    = c_LS_SE0;
            end
        end

        // NRZI: a 0 toggles the current level, a 1 holds it
        if (w_step) begin
            w_ls_nxt = (w_bit ? w_level : ~w_level) ? c_LS_J : c_LS_K;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= TX_IDLE;
            r_timer      <= '0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_line_state <= c_LS_J;
            r_dp         <= f_dp(c_LS_J);
            r_dn         <= f_dn(c_LS_J);
            r_oe         <= 1'b0;
            r_active     <= 1'b0;
            r_holdoff    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= ((r_state == TX_IDLE) || w_last) ? '0 : (r_timer + c_TIMER_W'(1));
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_line_state <= w_ls_nxt;
            r_dp         <= f_dp(w_ls_nxt);
            r_dn         <= f_dn(w_ls_nxt);
            r_oe         <= (w_state_nxt != TX_IDLE);
            r_active     <= (w_state_nxt != TX_IDLE);
            r_holdoff    <= (r_state == TX_EOP_J) && w_last;
        end
    end

    assign tx_active     = r_active;
    assign usb_dp_o      = r_dp;
    assign usb_dn_o      = r_dn;
    assign usb_oe        = r_oe;
    assign tx_line_state = r_line_state;

endmodule
`default_nettype wire
